// File: rtl/ram_tester.sv
// ram_tester: fills a 2^ADDR_W x DATA_W RAM with addr^seed, reads it back and
// reports the mismatch count, the first failing address and a pass flag.
module ram_tester #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [DATA_W-1:0] seed,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W:0]   err_count,
   output logic [ADDR_W-1:0] first_err_addr
);
   typedef enum logic [1:0] {IDLE, FILL, VERIFY, FINISH} state_t;
   state_t state, state_nx;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] seed_q, expected;
   logic last, accept, mismatch;
   assign last      = cnt == {ADDR_W{1'b1}};
   assign accept    = state == IDLE && start;
   assign expected  = cnt[DATA_W-1:0] ^ seed_q;
   assign mismatch  = state == VERIFY && ram_rdata != expected;
   assign ram_we    = state == FILL;
   assign ram_addr  = state == IDLE ? '0 : cnt;
   assign ram_wdata = state == FILL ? expected : '0;
   assign busy      = state != IDLE;
   assign done      = state == FINISH;
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = start ? (mode ? VERIFY : FILL) : IDLE;
         FILL:    state_nx = last ? VERIFY : FILL;
         VERIFY:  state_nx = last ? FINISH : VERIFY;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         seed_q         <= '0;
         err_count      <= '0;
         first_err_addr <= '0;
         pass           <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            cnt            <= '0;
            seed_q         <= seed;
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
         end
         // FILL wraps the counter back to 0 for VERIFY; VERIFY parks at the top
         if (state == FILL || (state == VERIFY && !last))
            cnt <= cnt + 1'b1;
         if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (err_count == '0)
               first_err_addr <= cnt;
         end
         if (state == FINISH)
            pass <= err_count == '0;
      end
   end
endmodule
